// File: rtl/prime_bench_ctl.sv
// prime_bench_ctl
// Benchmark controller for a prime generator core. It handshakes results out
// of the generator, keeps the most recent prime, counts primes and elapsed
// cycles, stops at a configurable limit or on generator error, and drives a
// small LED progress display. A start pulse restarts a run at any time.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       single-cycle pulse, (re)starts a run
//   pg_rst      reset to the generator core (high in IDLE and CLR)
//   pg_go       one-cycle request for the next prime
//   pg_ready    generator has a valid result
//   pg_error    generator overflow or error
//   pg_res      generator result
//   led         progress display (low NLED-1 bits) plus status LED (MSB)
//   busy        a run is in progress
//   done        run finished at LIMIT
//   fault       run ended on generator error
//   prime_cnt   number of primes accepted (saturating)
//   cycle_cnt   clocks spent in RUN and HOLD (saturating)
//   last_prime  most recently accepted prime
module prime_bench_ctl #(
    parameter int W        = 16,
    parameter int NLED     = 5,
    parameter int BAR_MODE = 0,
    parameter int LIMIT    = 0,
    parameter int CW       = 16,
    parameter int CYW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            pg_rst,
    output logic            pg_go,
    input  logic            pg_ready,
    input  logic            pg_error,
    input  logic [W-1:0]    pg_res,
    output logic [NLED-1:0] led,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [CW-1:0]   prime_cnt,
    output logic [CYW-1:0]  cycle_cnt,
    output logic [W-1:0]    last_prime
);

    localparam int NSEG = NLED - 1;
    localparam int SEGW = $clog2(NSEG + 1);

    // Segment width in value space: 2^W / NSEG rounded up.
    localparam longint unsigned STEP_L = ((64'd1 << W) + 64'(NSEG) - 64'd1) / 64'(NSEG);
    localparam logic [W:0] STEP = (W+1)'(STEP_L);
    localparam logic [W:0] LIM  = (W+1)'(LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_HOLD,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          state;
    logic [W:0]      bound;
    logic [SEGW-1:0] seg;
    logic            adv;
    logic            restart;

    function automatic logic [CW-1:0] sat_inc_cw(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CYW-1:0] sat_inc_cyw(input logic [CYW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Progress pattern for a given segment count.
    function automatic logic [NSEG-1:0] bar_of(input logic [SEGW-1:0] s);
        logic [NSEG+SEGW-1:0] ext;
        logic [NSEG-1:0]      v;
        ext = (NSEG+SEGW)'(s);
        v   = '0;
        for (int i = 0; i < NSEG; i++) begin
            if (BAR_MODE == 0)
                v[i] = ext[i];
            else
                v[i] = (int'(s) > i);
        end
        return v;
    endfunction

    // The display advances by at most one segment per cycle, so a large jump
    // in last_prime catches up over the following cycles (also in DONE/FAULT).
    always_comb begin
        adv = 1'b0;
        if (state != S_IDLE && state != S_CLR &&
            ({1'b0, last_prime} > bound) && (int'(seg) < NSEG))
            adv = 1'b1;
    end

    // A start pulse is honoured everywhere except in the one-cycle CLR state.
    always_comb begin
        restart = start && (state != S_CLR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pg_rst     <= 1'b1;
            pg_go      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            led        <= '0;
            prime_cnt  <= '0;
            cycle_cnt  <= '0;
            last_prime <= '0;
            bound      <= STEP;
            seg        <= '0;
        end else begin
            if (adv) begin
                bound          <= bound + STEP;
                seg            <= seg + 1'b1;
                led[NSEG-1:0]  <= bar_of(seg + 1'b1);
            end

            if (restart) begin
                // Abort-and-restart: any go pulse in flight is dropped and
                // the generator is held in reset for the CLR cycle.
                state      <= S_CLR;
                pg_rst     <= 1'b1;
                pg_go      <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
                fault      <= 1'b0;
                led        <= '0;
                prime_cnt  <= '0;
                cycle_cnt  <= '0;
                last_prime <= '0;
                bound      <= STEP;
                seg        <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        pg_rst <= 1'b1;
                    end

                    S_CLR: begin
                        state  <= S_RUN;
                        pg_rst <= 1'b0;
                        busy   <= 1'b1;
                    end

                    S_RUN: begin
                        cycle_cnt <= sat_inc_cyw(cycle_cnt);
                        if (pg_error) begin
                            state         <= S_FAULT;
                            busy          <= 1'b0;
                            fault         <= 1'b1;
                            led[NLED-1]   <= 1'b1;
                        end else if (pg_ready) begin
                            state      <= S_HOLD;
                            pg_go      <= 1'b1;
                            last_prime <= pg_res;
                            prime_cnt  <= sat_inc_cw(prime_cnt);
                        end
                    end

                    S_HOLD: begin
                        // One clock for the generator to register go; its
                        // stale ready is ignored here.
                        cycle_cnt <= sat_inc_cyw(cycle_cnt);
                        pg_go     <= 1'b0;
                        if (LIMIT != 0 && ({1'b0, last_prime} >= LIM)) begin
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            led[NLED-1] <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end

                    S_DONE: begin
                        state <= S_DONE;
                    end

                    S_FAULT: begin
                        state <= S_FAULT;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/prime_bench_ctl.md
Name: prime_bench_ctl

Overview:
- Parametrised benchmark controller for a prime generator core on small FPGA boards.
- Repeatedly handshakes results out of the generator and tracks the most recent prime.
- Counts primes and elapsed cycles, stops at a configurable limit or on generator error, and drives a configurable LED progress display.
- Sits between the board top (clock generator, power-on reset) and the generator core; supports restart without a board reset.

Parameters:
- W, 16: width of generator result, in bits (power of two, 8..32).
- NLED, 5: total LEDs. LED[NLED-1] is status; the low NLED-1 LEDs form the progress display (NLED >= 2).
- BAR_MODE, 0: progress display style. 0 = binary segment count, 1 = thermometer bar.
- LIMIT, 0: stop once a prime >= LIMIT has been accepted. 0 = run until generator error.
- CW, 16: width of prime counter.
- CYW, 32: width of cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; restarts a run from IDLE, DONE or FAULT
- pg_rst  out  1  reset to generator core
- pg_go  out  1  request the next prime from the generator
- pg_ready  in  1  generator has a valid result
- pg_error  in  1  generator overflow or error
- pg_res  in  W  generator result
- led  out  NLED  progress display plus status LED
- busy  out  1  a run is in progress
- done  out  1  run finished at LIMIT
- fault  out  1  run ended on generator error
- prime_cnt  out  CW  number of primes accepted
- cycle_cnt  out  CYW  clocks spent in RUN and HOLD
- last_prime  out  W  most recently accepted prime

Behaviour:
- Reset values: all outputs 0, except pg_rst = 1; state IDLE.
- Derived constants:
  - NSEG = NLED-1.
  - STEP = 2^W / NSEG, rounded up.
  - bound is a W+1-bit register, so it never wraps.
- State IDLE:
  - Entered after rst.
  - pg_rst = 1.
  - If start, go to CLR.
- State CLR (1 cycle):
  - pg_rst = 1.
  - Clears prime_cnt, cycle_cnt, last_prime, led and done/fault.
  - bound <= STEP.
  - Next state RUN.
- State RUN:
  - pg_rst = 0; busy = 1; cycle_cnt increments each cycle and saturates at all-ones.
  - pg_error = 1: go to FAULT (takes priority over pg_ready in the same cycle).
  - Otherwise pg_ready = 1:
    - pg_go <= 1 for exactly one cycle.
    - last_prime <= pg_res.
    - prime_cnt increments, saturating.
    - Next state HOLD.
- State HOLD (1 cycle):
  - pg_go = 0; busy = 1; cycle_cnt increments.
  - Gives the generator one clock to register go; pg_ready is ignored here.
  - If LIMIT != 0 and last_prime >= LIMIT, go to DONE; else go to RUN.
- State DONE:
  - done = 1; busy = 0.
  - Counters and last_prime frozen.
  - start goes to CLR.
- State FAULT:
  - fault = 1; busy = 0; last_prime holds the last valid prime.
  - start goes to CLR.
- start received while in RUN or HOLD goes to CLR (abort-and-restart); any pg_go pulse in flight is dropped.
- Progress display (runs independently each cycle while not in IDLE/CLR):
  - If last_prime > bound and seg < NSEG: bound += STEP and seg += 1.
  - At most one segment per cycle. A large jump catches up over several cycles, and catch-up continues in DONE/FAULT.
  - BAR_MODE 0: led[NSEG-1:0] = seg, truncated to NSEG bits.
  - BAR_MODE 1: led[i] = (seg > i).
- Status LED led[NLED-1] = fault | done, registered. It is steady when the run ends; it is not toggled.
- Simultaneous start and rst: rst wins.
- Throughput bound: at most one prime per two cycles.

Test Plan:
- Reset, then start, with a behavioural generator emitting 2,3,5,7,11 (ready one cycle after each go), W=8, LIMIT=11 -> exactly 5 go pulses, prime_cnt=5, last_prime=11, done=1, busy=0.
- pg_ready and pg_error asserted in the same cycle -> FAULT, no go pulse, prime_cnt unchanged, led[NLED-1]=1.
- W=8, NLED=5, BAR_MODE=1, one prime 200 -> seg climbs 1,2,3 on consecutive cycles (bounds 64,128,192), led[3:0] ends at 0111.
- BAR_MODE=0, primes up to 255 -> seg saturates at 4, led[3:0]=0100, no wrap.
- start pulse mid-RUN after 3 primes -> one cycle of pg_rst=1, counters zeroed, new run begins from prime 2.
- Run with CW=2 and 6 primes -> prime_cnt saturates at 3; cycle_cnt equals the cycles spent in RUN and HOLD.
